// File: rtl/mem_req_initiator.sv
// Memory self-test initiator: writes NUM_TXN LFSR words to a strided address
// sequence over a single-outstanding req/ready port, then reads them back and checks them.
module mem_req_initiator #(
    parameter int unsigned NUM_TXN     = 10,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_BASE   = 0,
    parameter int unsigned ADDR_STRIDE = 1,
    parameter logic [31:0] SEED        = 32'h0000_ACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    output logic              req_o,
    output logic              req_rnw_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [DATA_W-1:0] req_wdata_o,
    input  logic              req_ready_i,
    input  logic [DATA_W-1:0] req_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [15:0]       err_count_o,
    output logic [ADDR_W-1:0] first_err_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_REQ = 3'd1,
        S_WR_GAP = 3'd2,
        S_RD_REQ = 3'd3,
        S_RD_GAP = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [15:0]       LAST_IDX = 16'(NUM_TXN - 1);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(ADDR_BASE);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(ADDR_STRIDE);

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        lfsr_next = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    state_t            state_q, state_d;
    logic [15:0]       idx_q, idx_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              req_q, req_d;
    logic              rnw_q, rnw_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;

    // Next-state logic; outputs are derived from the next state so they leave flops.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lfsr_d  = lfsr_q;
        addr_d  = addr_q;
        err_d   = err_q;
        first_d = first_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_WR_REQ;
                    idx_d   = 16'd0;
                    err_d   = 16'd0;
                    first_d = {ADDR_W{1'b0}};
                    lfsr_d  = SEED;
                    addr_d  = BASE_A;
                end else begin
                    state_d = state_q;
                end
            end
            S_WR_REQ: begin
                if (req_ready_i) begin
                    lfsr_d  = lfsr_next(lfsr_q);
                    state_d = S_WR_GAP;
                end else begin
                    state_d = S_WR_REQ;
                end
            end
            S_WR_GAP: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = 16'd0;
                    lfsr_d  = SEED;
                    addr_d  = BASE_A;
                    state_d = S_RD_REQ;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    addr_d  = addr_q + STRIDE_A;
                    state_d = S_WR_REQ;
                end
            end
            S_RD_REQ: begin
                if (req_ready_i) begin
                    if (req_rdata_i != lfsr_q[DATA_W-1:0]) begin
                        // First-error address is latched only on the first miscompare.
                        if (err_q == 16'd0) begin
                            first_d = addr_q;
                        end else begin
                            first_d = first_q;
                        end
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'd1;
                        end else begin
                            err_d = err_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    lfsr_d  = lfsr_next(lfsr_q);
                    state_d = S_RD_GAP;
                end else begin
                    state_d = S_RD_REQ;
                end
            end
            S_RD_GAP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    addr_d  = addr_q + STRIDE_A;
                    state_d = S_RD_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_d   = (state_d == S_WR_REQ) || (state_d == S_RD_REQ);
        rnw_d   = (state_d == S_RD_REQ);
        wdata_d = (state_d == S_WR_REQ) ? lfsr_d[DATA_W-1:0] : {DATA_W{1'b0}};
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
        pass_d  = done_d && (err_d == 16'd0);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 16'd0;
            lfsr_q  <= SEED;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            req_q   <= 1'b0;
            rnw_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 16'd0;
            first_q <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lfsr_q  <= lfsr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            rnw_q   <= rnw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign req_o            = req_q;
    assign req_rnw_o        = rnw_q;
    assign req_addr_o       = addr_q;
    assign req_wdata_o      = wdata_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Scoreboard bench for mem_req_initiator: a behavioural memory answers requests while
// expected transactions, queued at start, are popped and compared on every completion.
module tb_mem_req_initiator;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam logic [31:0] SEED = 32'h0000_ACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_a, start_b, ready, sel;
    logic [DW-1:0] rdata;
    logic ready_a, ready_b;

    logic req_a, rnw_a, busy_a, done_a, pass_a;
    logic [AW-1:0] addr_a, first_a;
    logic [DW-1:0] wdata_a;
    logic [15:0] err_a;
    logic req_b, rnw_b, busy_b, done_b, pass_b;
    logic [AW-1:0] addr_b, first_b;
    logic [DW-1:0] wdata_b;
    logic [15:0] err_b;

    assign ready_a = ready & ~sel;
    assign ready_b = ready & sel;

    mem_req_initiator u_dut_a (
        .clk(clk), .reset(reset), .start_i(start_a),
        .req_o(req_a), .req_rnw_o(rnw_a), .req_addr_o(addr_a), .req_wdata_o(wdata_a),
        .req_ready_i(ready_a), .req_rdata_i(rdata),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
        .err_count_o(err_a), .first_err_addr_o(first_a)
    );

    mem_req_initiator #(.NUM_TXN(3), .ADDR_BASE(1000), .ADDR_STRIDE(100)) u_dut_b (
        .clk(clk), .reset(reset), .start_i(start_b),
        .req_o(req_b), .req_rnw_o(rnw_b), .req_addr_o(addr_b), .req_wdata_o(wdata_b),
        .req_ready_i(ready_b), .req_rdata_i(rdata),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
        .err_count_o(err_b), .first_err_addr_o(first_b)
    );

    logic m_req, m_rnw, m_busy, m_done, m_pass;
    logic [AW-1:0] m_addr, m_first;
    logic [DW-1:0] m_wdata;
    logic [15:0] m_err;
    assign m_req   = sel ? req_b   : req_a;
    assign m_rnw   = sel ? rnw_b   : rnw_a;
    assign m_addr  = sel ? addr_b  : addr_a;
    assign m_wdata = sel ? wdata_b : wdata_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_pass  = sel ? pass_b  : pass_a;
    assign m_err   = sel ? err_b   : err_a;
    assign m_first = sel ? first_b : first_a;

    logic [DW-1:0] mem [0:1023];
    bit            flip_map [0:1023];
    logic [42:0]   sbq [$];
    logic [AW-1:0] rec_addr [3];
    logic [DW-1:0] rec_wd [2];
    int n_wr;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_lfsr(input logic [31:0] l);
        logic [31:0] r;
        r = {1'b0, l[31:1]};
        if (l[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    task automatic push_expected(input int n, input int base, input int stride);
        logic [31:0] l;
        int a;
        l = SEED;
        for (int i = 0; i < n; i++) begin
            a = (base + i * stride) % 1024;
            sbq.push_back({1'b0, AW'(a), l});
            l = model_lfsr(l);
        end
        for (int i = 0; i < n; i++) begin
            a = (base + i * stride) % 1024;
            sbq.push_back({1'b1, AW'(a), 32'h0000_0000});
        end
    endtask

    // Called at a negedge; leaves start high when hold is set.
    task automatic pulse_start(input bit hold);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            start_a = 1'b0;
            start_b = 1'b0;
        end
    endtask

    // Memory responder plus protocol checks; one iteration per clock, from a negedge.
    task automatic run_txns(input int waits, input int budget, output int edges);
        int wcnt = 0;
        int gap = 0;
        bit holding = 1'b0;
        bit first = 1'b1;
        logic [42:0] held, obs, ex;
        edges = 0;
        while (!m_done && edges < budget) begin
            rdata = $urandom;
            if (m_req) begin
                obs = {m_rnw, m_addr, m_wdata};
                if (holding) begin
                    chk("hold", 64'(obs), 64'(held));
                end else begin
                    if (!first) chk("gap", 64'(gap), 64'(1));
                    first = 1'b0;
                    holding = 1'b1;
                    held = obs;
                end
                if (wcnt == waits) begin
                    ready = 1'b1;
                    wcnt = 0;
                    holding = 1'b0;
                    gap = 0;
                    if (sbq.size() == 0) begin
                        chk("extra_txn", 64'(sbq.size()), 64'(1));
                    end else begin
                        ex = sbq.pop_front();
                        chk("txn", 64'(obs), 64'(ex));
                    end
                    if (m_rnw) begin
                        rdata = mem[m_addr] ^ {31'b0, flip_map[m_addr]};
                    end else begin
                        mem[m_addr] = m_wdata;
                        if (n_wr < 3) rec_addr[n_wr] = m_addr;
                        if (n_wr < 2) rec_wd[n_wr] = m_wdata;
                        n_wr++;
                    end
                end else begin
                    ready = 1'b0;
                    wcnt++;
                end
            end else begin
                if (holding) chk("req_drop", 64'(m_req), 64'(1));
                holding = 1'b0;
                ready = 1'($urandom_range(0, 1));
                gap++;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        ready = 1'b0;
    endtask

    initial begin
        int e;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; ready = 1'b0; sel = 1'b0;
        rdata = '0;
        n_wr = 0;
        for (int i = 0; i < 1024; i++) flip_map[i] = 1'b0;

        #1;
        chk("rst_req",   64'(req_a),   64'(0));
        chk("rst_busy",  64'(busy_a),  64'(0));
        chk("rst_done",  64'(done_a),  64'(0));
        chk("rst_pass",  64'(pass_a),  64'(0));
        chk("rst_err",   64'(err_a),   64'(0));
        chk("rst_first", 64'(first_a), 64'(0));
        chk("rst_addr",  64'(addr_a),  64'(0));
        chk("rst_wdata", 64'(wdata_a), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Ideal memory
        n_wr = 0;
        push_expected(10, 0, 1);
        pulse_start(1'b0);
        run_txns(0, 200, e);
        chk("t1_edges", 64'(e), 64'(40));
        chk("t1_done",  64'(m_done), 64'(1));
        chk("t1_pass",  64'(m_pass), 64'(1));
        chk("t1_err",   64'(m_err),  64'(0));
        chk("t1_busy",  64'(m_busy), 64'(0));
        chk("t1_wd0",   64'(rec_wd[0]), 64'(32'h0000_ACE1));
        chk("t1_wd1",   64'(rec_wd[1]), 64'(32'h8020_5673));
        chk("t1_sbq",   64'(sbq.size()), 64'(0));

        // Three wait cycles per access
        push_expected(10, 0, 1);
        pulse_start(1'b0);
        run_txns(3, 400, e);
        chk("t2_edges", 64'(e), 64'(100));
        chk("t2_pass",  64'(m_pass), 64'(1));
        chk("t2_sbq",   64'(sbq.size()), 64'(0));

        // Bit-0 faults at addresses 4 and 7
        flip_map[4] = 1'b1;
        flip_map[7] = 1'b1;
        push_expected(10, 0, 1);
        pulse_start(1'b0);
        run_txns(0, 200, e);
        chk("t3_done",  64'(m_done),  64'(1));
        chk("t3_err",   64'(m_err),   64'(2));
        chk("t3_first", 64'(m_first), 64'(4));
        chk("t3_pass",  64'(m_pass),  64'(0));
        flip_map[4] = 1'b0;
        flip_map[7] = 1'b0;

        // Reset while write 3 is outstanding
        push_expected(10, 0, 1);
        pulse_start(1'b0);
        run_txns(0, 6, e);
        chk("t4_req_w3",  64'(m_req),  64'(1));
        chk("t4_addr_w3", 64'(m_addr), 64'(3));
        #2 reset = 1'b1;
        #1;
        chk("t4_rst_req",  64'(m_req),  64'(0));
        chk("t4_rst_busy", 64'(m_busy), 64'(0));
        chk("t4_rst_done", 64'(m_done), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        sbq.delete();
        n_wr = 0;
        push_expected(10, 0, 1);
        pulse_start(1'b0);
        run_txns(0, 200, e);
        chk("t4_addr0", 64'(rec_addr[0]), 64'(0));
        chk("t4_wd0",   64'(rec_wd[0]),   64'(32'h0000_ACE1));
        chk("t4_edges", 64'(e), 64'(40));
        chk("t4_pass",  64'(m_pass), 64'(1));

        // start held high: one run, then restart from DONE
        flip_map[4] = 1'b1;
        flip_map[7] = 1'b1;
        push_expected(10, 0, 1);
        pulse_start(1'b1);
        run_txns(0, 200, e);
        chk("t5_edges", 64'(e), 64'(40));
        chk("t5_done",  64'(m_done), 64'(1));
        chk("t5_err",   64'(m_err),  64'(2));
        chk("t5_sbq",   64'(sbq.size()), 64'(0));
        flip_map[4] = 1'b0;
        flip_map[7] = 1'b0;
        push_expected(10, 0, 1);
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        chk("t5_rs_done", 64'(m_done), 64'(0));
        chk("t5_rs_err",  64'(m_err),  64'(0));
        chk("t5_rs_busy", 64'(m_busy), 64'(1));
        run_txns(0, 200, e);
        chk("t5_rs_edges", 64'(e), 64'(40));
        chk("t5_rs_pass",  64'(m_pass), 64'(1));

        // Second instance: base 1000, stride 100, three transactions
        sel = 1'b1;
        n_wr = 0;
        push_expected(3, 1000, 100);
        pulse_start(1'b0);
        run_txns(0, 100, e);
        chk("t6_edges", 64'(e), 64'(12));
        chk("t6_a0",    64'(rec_addr[0]), 64'(1000));
        chk("t6_a1",    64'(rec_addr[1]), 64'(76));
        chk("t6_a2",    64'(rec_addr[2]), 64'(176));
        chk("t6_pass",  64'(m_pass), 64'(1));
        chk("t6_err",   64'(m_err),  64'(0));
        chk("t6_sbq",   64'(sbq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_req_initiator.md
Name: mem_req_initiator

Overview:
- Hardware initiator for the single-outstanding req/ready memory interface; it is the counterpart of the memory responder.
- On start it writes NUM_TXN pseudo-random words to a strided address sequence, then reads them back in the same order and compares each read against the regenerated expected data.
- It reports done, pass/fail, error count and the first failing address.
- Used as an on-chip memory self-test and bring-up traffic source.

Parameters:
NUM_TXN, 10, number of write transactions, and the same number of readback transactions (1..65535)
ADDR_W, 10, request address width
DATA_W, 32, request data width (1..32)
ADDR_BASE, 0, address of transaction 0
ADDR_STRIDE, 1, address increment per transaction; addresses wrap modulo 2^ADDR_W
SEED, 32'h0000_ACE1, LFSR seed; must be nonzero

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start_i  in  1  start pulse, sampled only in IDLE or DONE
req_o  out  1  request valid
req_rnw_o  out  1  1 = read, 0 = write
req_addr_o  out  ADDR_W  request address
req_wdata_o  out  DATA_W  write data
req_ready_i  in  1  responder completes the transaction this cycle
req_rdata_i  in  DATA_W  read data, valid when req_ready_i=1 on a read
busy_o  out  1  test in progress
done_o  out  1  test finished; held until the next start
pass_o  out  1  valid when done_o=1; high when err_count_o==0
err_count_o  out  16  readback mismatches, saturates at 16'hFFFF
first_err_addr_o  out  ADDR_W  address of the first mismatch; 0 if none

Behaviour:
- Reset (async): state IDLE. All outputs 0, LFSR=SEED, idx=0. Reset mid-test drops req_o immediately; no completion is reported.
- All outputs are registered. Handshake: a transaction completes on a rising edge where req_o=1 and req_ready_i=1. req_rnw_o, req_addr_o and req_wdata_o stay stable while req_o=1. req_ready_i is ignored while req_o=0. After each completion, req_o is low for exactly one cycle.
- Address of transaction idx = (ADDR_BASE + idx*ADDR_STRIDE) mod 2^ADDR_W.
- Data: 32-bit Galois LFSR, next = (lfsr>>1) ^ (lfsr[0] ? 32'h8020_0003 : 0). The data for the current transaction is lfsr[DATA_W-1:0]. The LFSR advances once per completed transaction.
- IDLE: on start_i=1, clear idx, err_count_o and first_err_addr_o; set LFSR=SEED; go to WR_REQ.
- WR_REQ: req_o=1, rnw=0. On completion, advance the LFSR and go to WR_GAP.
- WR_GAP: req_o=0.
  - If idx==NUM_TXN-1: idx=0, LFSR=SEED, go to RD_REQ.
  - Otherwise idx++, go to WR_REQ.
- RD_REQ: req_o=1, rnw=1, req_wdata_o=0. On completion:
  - Compare req_rdata_i against lfsr[DATA_W-1:0].
  - On mismatch: if err_count_o==0, capture req_addr_o into first_err_addr_o; then increment err_count_o with saturation.
  - Advance the LFSR and go to RD_GAP.
- RD_GAP: req_o=0.
  - If idx==NUM_TXN-1: go to DONE.
  - Otherwise idx++, go to RD_REQ.
- busy_o=1 in every state except IDLE and DONE.
- DONE: done_o=1, pass_o=(err_count_o==0); results held. start_i=1 clears done_o/pass_o and restarts exactly as from IDLE.
- start_i is ignored while busy_o=1.
- Latency with zero-wait ready: 2 cycles per transaction. done_o rises 4*NUM_TXN edges after the edge that samples start_i.
- Address wrap is plain modulo arithmetic. idx has no wrap beyond NUM_TXN-1.

Test Plan:
1. Defaults; ideal memory with ready high whenever req_o=1. Pulse start -> writes to addresses 0..9, then reads 0..9 in order. wdata of txn0 = 32'h0000_ACE1 and of txn1 = 32'h8020_5673. done_o high 40 cycles after the start edge; pass_o=1, err_count_o=0.
2. Memory with 3 wait cycles per access -> req_o held 4 cycles per transaction with addr/wdata constant; one idle cycle between transactions; pass_o=1 after 100 cycles.
3. Memory flips bit 0 of read data at addresses 4 and 7 -> err_count_o=2, first_err_addr_o=4, pass_o=0.
4. Assert reset during write 3 -> req_o, busy_o and done_o are 0 without waiting for a clock edge. The next start restarts at address 0 with wdata 32'h0000_ACE1.
5. start_i held high for the whole run -> exactly one test executes. When DONE is reached with start_i still high, the test restarts and err_count_o is cleared.
6. ADDR_BASE=1000, ADDR_STRIDE=100, NUM_TXN=3 -> addresses 1000, 76, 176 for both writes and reads; pass_o=1.
